// File: rtl/gclk_pkg.sv
// Shared constants and channel state type for the
// multi-channel clock divider.
package gclk_pkg;

  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

endpackage

// File: rtl/gclk_div_ch.sv
// One divider channel: CE pulse every act+1 cycles,
// toggle clock CKO, staged ratio reload with ack.
module gclk_div_ch
  import gclk_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         CP,
  input  logic         CD,
  input  logic         EN,
  input  logic         LD,
  input  logic [W-1:0] DIV,
  output logic         LACK,
  output logic         CE,
  output logic         CKO,
  output logic         BUSY
);

  state_t         r_state;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_act;
  logic [W-1:0]   r_pend;
  logic           r_pflag;
  logic           r_fresh;
  logic           r_lack;
  logic           r_ce;
  logic           r_cko;
  logic           r_busy;

  logic           w_live;
  logic           w_quit;
  logic           w_tc;
  logic           w_apply;
  logic           w_done;
  logic [W-1:0]   w_eff;

  // A ratio loaded just before start counts from the very first cycle.
  always_comb begin
    w_live  = (r_state != IDLE);
    w_quit  = (r_state == RUN) && !EN && !r_cko &&
              (r_cnt == '0);
    w_eff   = (r_fresh && r_pflag) ? r_pend : r_act;
    w_tc    = w_live && !w_quit && (r_cnt == w_eff);
    w_apply = r_pflag && (!w_live || r_fresh || w_tc);
    w_done  = w_quit || (w_tc && !EN && r_cko);
  end

  always_ff @(posedge CP) begin
    if (!CD) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_act   <= '0;
      r_pend  <= '0;
      r_pflag <= 1'b0;
      r_fresh <= 1'b0;
      r_lack  <= 1'b0;
      r_ce    <= 1'b0;
      r_cko   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_lack  <= w_apply;
      r_fresh <= 1'b0;
      if (w_apply) begin
        r_act   <= r_pend;
        r_pflag <= 1'b0;
      end
      if (LD) begin
        r_pend  <= DIV;
        r_pflag <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          r_cnt   <= '0;
          r_ce    <= 1'b0;
          r_cko   <= 1'b0;
          r_busy  <= EN;
          r_fresh <= EN;
          if (EN) r_state <= RUN;
        end
        RUN, STOP: begin
          r_ce  <= w_tc;
          r_cnt <= (w_tc || w_quit) ? '0 : r_cnt + 1'b1;
          // Leave only on a low phase so CKO is never cut short.
          if (w_done) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_cko   <= 1'b0;
          end else begin
            r_state <= EN ? RUN : STOP;
            r_busy  <= 1'b1;
            if (w_tc) r_cko <= ~r_cko;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
          r_ce    <= 1'b0;
          r_cko   <= 1'b0;
        end
      endcase
    end
  end

  assign LACK = r_lack;
  assign CE   = r_ce;
  assign CKO  = r_cko;
  assign BUSY = r_busy;

endmodule

// File: rtl/gclk_divn.sv
// NCH independent divider channels sharing one clock
// and one synchronous active-low reset.
module gclk_divn
  import gclk_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int W   = W_DEF
) (
  input  logic             CP,
  input  logic             CD,
  input  logic [NCH-1:0]   EN,
  input  logic [NCH-1:0]   LD,
  input  logic [NCH*W-1:0] DIV,
  output logic [NCH-1:0]   LACK,
  output logic [NCH-1:0]   CE,
  output logic [NCH-1:0]   CKO,
  output logic [NCH-1:0]   BUSY
);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    gclk_div_ch #(
      .W(W)
    ) u_ch (
      .CP   (CP),
      .CD   (CD),
      .EN   (EN[gi]),
      .LD   (LD[gi]),
      .DIV  (DIV[gi*W +: W]),
      .LACK (LACK[gi]),
      .CE   (CE[gi]),
      .CKO  (CKO[gi]),
      .BUSY (BUSY[gi])
    );
  end

endmodule

// File: tb/tb_gclk_divn.sv
// Randomised scoreboard bench for gclk_divn with
// directed timing checks and free-running period checks.
module tb_gclk_divn;

  localparam int NCH = 4;
  localparam int W   = 8;

  logic             CP = 1'b0;
  logic             CD;
  logic [NCH-1:0]   EN;
  logic [NCH-1:0]   LD;
  logic [NCH*W-1:0] DIV;
  logic [NCH-1:0]   LACK;
  logic [NCH-1:0]   CE;
  logic [NCH-1:0]   CKO;
  logic [NCH-1:0]   BUSY;

  gclk_divn #(.NCH(NCH), .W(W)) dut (
    .CP   (CP),
    .CD   (CD),
    .EN   (EN),
    .LD   (LD),
    .DIV  (DIV),
    .LACK (LACK),
    .CE   (CE),
    .CKO  (CKO),
    .BUSY (BUSY)
  );

  always #5 CP = ~CP;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s @%0t: got %0d want %0d", nm, $time, a, e);
    end
  endfunction

  // Behavioural model: mode 0 idle, 1 run, 2 stopping.
  typedef struct {
    int mode;
    int pos;
    int ratio;
    int nxt;
    bit has_nxt;
    bit just_go;
    bit ce;
    bit cko;
    bit ack;
  } ch_t;

  ch_t m[NCH];
  logic [15:0] q[$];

  function automatic void mstep(int c, bit en, bit ld, int dv, bit cd);
    ch_t s;
    ch_t n;
    int  r;
    bit  quit;
    bit  wrap;
    s = m[c];
    n = s;
    if (!cd) begin
      n = '{default: 0};
    end else begin
      quit = (s.mode == 1) && !en && !s.cko && (s.pos == 0);
      r    = (s.just_go && s.has_nxt) ? s.nxt : s.ratio;
      wrap = (s.mode != 0) && !quit && (s.pos == r);
      n.ack     = 0;
      n.just_go = 0;
      if (s.has_nxt && (s.mode == 0 || s.just_go || wrap)) begin
        n.ratio   = s.nxt;
        n.has_nxt = 0;
        n.ack     = 1;
      end
      if (ld) begin
        n.nxt     = dv;
        n.has_nxt = 1;
      end
      if (s.mode == 0) begin
        n.pos = 0;
        n.ce  = 0;
        n.cko = 0;
        if (en) begin
          n.mode    = 1;
          n.just_go = 1;
        end
      end else if (quit) begin
        n.mode = 0;
        n.pos  = 0;
        n.ce   = 0;
        n.cko  = 0;
      end else begin
        n.ce  = wrap;
        n.pos = wrap ? 0 : s.pos + 1;
        if (wrap) n.cko = !s.cko;
        if (en) n.mode = 1;
        else if (wrap && s.cko) n.mode = 0;
        else n.mode = 2;
      end
    end
    m[c] = n;
  endfunction

  task automatic tick(input logic [3:0] en, input logic [3:0] ld,
                      input logic [31:0] dv, input logic cd);
    logic [3:0] el, ec, ek, eb;
    @(negedge CP);
    EN  = en;
    LD  = ld;
    DIV = dv;
    CD  = cd;
    for (int c = 0; c < NCH; c++) begin
      mstep(c, en[c], ld[c], int'(dv[c*W +: W]), cd);
      el[c] = m[c].ack;
      ec[c] = m[c].ce;
      ek[c] = m[c].cko;
      eb[c] = (m[c].mode != 0);
    end
    q.push_back({el, ec, ek, eb});
  endtask

  task automatic look;
    @(posedge CP);
    #1;
  endtask

  bit         pchk = 0;
  int         cyc = 0;
  int         last_ce[NCH];
  int         last_up[NCH];
  int         rat[NCH] = '{0, 1, 5, 255};
  logic [3:0] prev_cko = '0;

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge CP);
      #1;
      cyc++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("lack", int'(LACK), int'(e[15:12]));
        chk("ce", int'(CE), int'(e[11:8]));
        chk("cko", int'(CKO), int'(e[7:4]));
        chk("busy", int'(BUSY), int'(e[3:0]));
      end
      if (pchk) begin
        for (int c = 0; c < NCH; c++) begin
          if (CE[c]) begin
            if (last_ce[c] >= 0)
              chk($sformatf("ce_per%0d", c), cyc - last_ce[c], rat[c] + 1);
            last_ce[c] = cyc;
          end
          if (CKO[c] && !prev_cko[c]) begin
            if (last_up[c] >= 0)
              chk($sformatf("cko_per%0d", c), cyc - last_up[c],
                  2 * (rat[c] + 1));
            last_up[c] = cyc;
          end
        end
      end
      prev_cko = CKO;
    end
  end

  initial begin : stim
    logic [3:0] en_r;
    logic [3:0] ld_r;
    logic [31:0] dv_r;
    CD  = 1'b0;
    EN  = '0;
    LD  = '0;
    DIV = '0;
    for (int c = 0; c < NCH; c++) m[c] = '{default: 0};

    tick(4'h0, 4'h0, 0, 1'b0);
    tick(4'hF, 4'hF, 32'h0505_0505, 1'b0);
    look();
    chk("rst_out", int'({LACK, CE, CKO, BUSY}), 0);

    // Load ratio 3 and start on the same edge.
    tick(4'h1, 4'h1, 32'h3, 1'b1);
    look();
    chk("start_busy", int'(BUSY[0]), 1);
    chk("start_lack", int'(LACK[0]), 0);
    tick(4'h1, 4'h0, 0, 1'b1);
    look();
    chk("ack_next", int'(LACK[0]), 1);
    chk("ce_early", int'(CE[0]), 0);
    for (int i = 2; i <= 12; i++) begin
      tick(4'h1, 4'h0, 0, 1'b1);
      look();
      chk("ce_r3", int'(CE[0]), int'(i % 4 == 0));
      chk("cko_r3", int'(CKO[0]), (i / 4) % 2);
      chk("lack_quiet", int'(LACK[0]), 0);
    end

    // Reset with a pending ratio discards it silently.
    tick(4'h1, 4'h1, 32'h7, 1'b1);
    tick(4'h1, 4'h1, 32'h9, 1'b0);
    look();
    chk("rst_mid", int'({LACK, CE, CKO, BUSY}), 0);
    tick(4'h0, 4'h0, 0, 1'b1);
    look();
    chk("rel_idle", int'({LACK, BUSY}), 0);
    tick(4'h1, 4'h0, 0, 1'b1);
    look();
    chk("r0_busy", int'(BUSY[0]), 1);
    chk("r0_ce0", int'(CE[0]), 0);
    tick(4'h1, 4'h0, 0, 1'b1);
    look();
    chk("r0_ce1", int'(CE[0]), 1);
    chk("r0_cko1", int'(CKO[0]), 1);
    chk("r0_nolack", int'(LACK[0]), 0);
    tick(4'h1, 4'h0, 0, 1'b1);
    look();
    chk("r0_ce2", int'(CE[0]), 1);
    chk("r0_cko2", int'(CKO[0]), 0);
    tick(4'h0, 4'h0, 0, 1'b1);
    look();
    chk("r0_off", int'({BUSY[0], CKO[0], CE[0]}), 0);

    // Four concurrent ratios, periods measured over 1024+ cycles.
    tick(4'h0, 4'hF, 32'hFF05_0100, 1'b1);
    tick(4'h0, 4'h0, 0, 1'b1);
    look();
    chk("ack_idle", int'(LACK), 15);
    for (int c = 0; c < NCH; c++) begin
      last_ce[c] = -1;
      last_up[c] = -1;
    end
    pchk = 1'b1;
    repeat (1040) tick(4'hF, 4'h0, 0, 1'b1);
    pchk = 1'b0;
    repeat (600) tick(4'h0, 4'h0, 0, 1'b1);
    look();
    chk("all_idle", int'(BUSY), 0);

    en_r = '0;
    repeat (3000) begin
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 19) == 0) en_r[c] = ~en_r[c];
        ld_r[c] = ($urandom_range(0, 14) == 0);
        dv_r[c*W +: W] = ($urandom_range(0, 7) == 0) ?
                         8'($urandom) : 8'($urandom_range(0, 6));
      end
      tick(en_r, ld_r, dv_r, ($urandom_range(0, 299) != 0));
    end
    tick(4'h0, 4'h0, 0, 1'b1);
    repeat (3) @(posedge CP);
    #2;
    chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
